// File: rtl/priority_arb_n.sv
// priority_arb_n: registered fixed-priority / round-robin arbiter with valid/ready grant handshake.
// Define PRIORITY_ARB_N_LOCK_EN to build the grant-lock (LOCKED state); otherwise i_lock is ignored.
module priority_arb_n #(
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(WIDTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_req,
   input  logic             i_rr_mode,
   input  logic             i_lock,
   output logic             o_gnt_valid,
   input  logic             i_gnt_ready,
   output logic [AW-1:0]    o_gnt_idx,
   output logic [WIDTH-1:0] o_gnt_onehot
);
   localparam int PW = $clog2(WIDTH);
   localparam logic [PW-1:0] TOP = PW'(WIDTH - 1);
`ifdef PRIORITY_ARB_N_LOCK_EN
   typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;
`else
   typedef enum logic [0:0] {IDLE, GRANT} state_t;
`endif
   state_t r_state;
   logic [PW-1:0] r_ptr, r_win, w_ptr_nxt, w_fix, w_rr, w_win, w_c;
   logic w_arb, w_hold;
   assign w_arb = (r_state == IDLE) || i_gnt_ready;
   // an arbitration event while presenting is an acceptance, so the rr search starts from the advanced pointer
   assign w_ptr_nxt = (r_state != IDLE && i_rr_mode) ? ((r_win == '0) ? TOP : r_win - 1'b1) : r_ptr;
`ifdef PRIORITY_ARB_N_LOCK_EN
   assign w_hold = (r_state != IDLE) && i_lock && i_req[r_win];
`else
   logic w_unused;
   assign w_hold   = 1'b0;
   assign w_unused = i_lock;
`endif
   always_comb begin
      w_fix = '0;
      w_rr  = '0;
      w_c   = '0;
      for (int i = 0; i < WIDTH; i++)
         if (i_req[i]) w_fix = PW'(i);
      // descending from the pointer with wrap; the smallest distance is assigned last and wins
      for (int k = WIDTH - 1; k >= 0; k--) begin
         w_c = (w_ptr_nxt >= PW'(k)) ? w_ptr_nxt - PW'(k) : w_ptr_nxt + PW'(WIDTH - k);
         if (i_req[w_c]) w_rr = w_c;
      end
      w_win = i_rr_mode ? w_rr : w_fix;
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_ptr        <= TOP;
         r_win        <= '0;
         o_gnt_valid  <= 1'b0;
         o_gnt_idx    <= '0;
         o_gnt_onehot <= '0;
      end else if (w_arb && !w_hold) begin
         r_ptr        <= w_ptr_nxt;
         r_state      <= (|i_req) ? GRANT : IDLE;
         r_win        <= w_win;
         o_gnt_valid  <= |i_req;
         o_gnt_idx    <= (|i_req) ? AW'(w_win) + AW'(1) : '0;
         o_gnt_onehot <= (|i_req) ? {{(WIDTH-1){1'b0}}, 1'b1} << w_win : '0;
`ifdef PRIORITY_ARB_N_LOCK_EN
      end else if (w_arb) begin
         r_state <= LOCKED;
`endif
      end
endmodule

// File: tb/tb_priority_arb_n.sv
// tb_priority_arb_n: directed scoreboard bench for priority_arb_n (WIDTH=8).
// Lock expectations follow PRIORITY_ARB_N_LOCK_EN.
module tb_priority_arb_n;
   localparam int WIDTH = 8;
   localparam int AW = 4;
   typedef struct {
      string          tag;
      logic           v;
      logic [AW-1:0]  idx;
   } exp_t;
   logic clk = 1'b0, rst_n = 1'b0, rr_mode = 1'b0, lock = 1'b0, gnt_ready = 1'b0, gnt_valid;
   logic [WIDTH-1:0] req = '0, gnt_onehot;
   logic [AW-1:0] gnt_idx;
   exp_t q[$];
   int n_checks = 0, n_errors = 0;
   always #5 clk = ~clk;
   priority_arb_n #(.WIDTH(WIDTH)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_rr_mode(rr_mode), .i_lock(lock),
      .o_gnt_valid(gnt_valid), .i_gnt_ready(gnt_ready), .o_gnt_idx(gnt_idx), .o_gnt_onehot(gnt_onehot)
   );
   task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic expect_out(input string tag, input logic v, input logic [AW-1:0] idx);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      e.idx = idx;
      q.push_back(e);
   endtask
   task automatic check_out();
      exp_t e;
      logic [WIDTH-1:0] oh;
      if (q.size() == 0) begin
         n_checks++;
         n_errors++;
         $error("FAIL scoreboard got=empty exp=entry");
         return;
      end
      e  = q.pop_front();
      oh = (e.idx == 0) ? '0 : WIDTH'(1) << (e.idx - 1);
      cmp({e.tag, ".valid"}, 64'(gnt_valid), 64'(e.v));
      cmp({e.tag, ".idx"}, 64'(gnt_idx), 64'(e.idx));
      cmp({e.tag, ".onehot"}, 64'(gnt_onehot), 64'(oh));
   endtask
   task automatic step(input string tag, input logic v, input logic [AW-1:0] idx);
      expect_out(tag, v, idx);
      @(posedge clk);
      #1;
      check_out();
   endtask
   initial begin
      req = 8'hFF;
      gnt_ready = 1'b1;
      for (int i = 0; i < 3; i++) step("reset", 1'b0, 4'd0);
      rst_n = 1'b1;
      req = '0;
      step("idle", 1'b0, 4'd0);
      step("idle", 1'b0, 4'd0);
      for (int n = 1; n <= 8; n++) begin
         req = WIDTH'((1 << n) - 1);
         step("fixed", 1'b1, AW'(n));
      end
      req = '0;
      step("fixed_zero", 1'b0, 4'd0);
      rr_mode = 1'b1;
      req = 8'b10010010;
      for (int r = 0; r < 2; r++) begin
         step("rr", 1'b1, 4'd8);
         step("rr", 1'b1, 4'd5);
         step("rr", 1'b1, 4'd2);
      end
      rr_mode = 1'b0;
      req = 8'h10;
      step("bp_setup", 1'b1, 4'd5);
      gnt_ready = 1'b0;
      req = 8'h80;
      repeat (4) step("bp_hold", 1'b1, 4'd5);
      gnt_ready = 1'b1;
      step("bp_release", 1'b1, 4'd8);
      req = 8'b10010010;
      rr_mode = 1'b1;
      gnt_ready = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      expect_out("async_rst", 1'b0, 4'd0);
      check_out();
      #1 rst_n = 1'b1;
      gnt_ready = 1'b1;
      step("rr_restart", 1'b1, 4'd8);
      step("rr_restart", 1'b1, 4'd5);
      step("rr_restart", 1'b1, 4'd2);
      lock = 1'b1;
      req = 8'b00100100;
`ifdef PRIORITY_ARB_N_LOCK_EN
      repeat (4) step("lock_hold", 1'b1, 4'd6);
      lock = 1'b0;
      step("lock_exit", 1'b1, 4'd3);
`else
      step("lock_ignored", 1'b1, 4'd6);
      step("lock_ignored", 1'b1, 4'd3);
      step("lock_ignored", 1'b1, 4'd6);
      step("lock_ignored", 1'b1, 4'd3);
      lock = 1'b0;
      step("lock_ignored", 1'b1, 4'd6);
`endif
      req = 8'b00001000;
      repeat (3) step("rr_single", 1'b1, 4'd4);
      req = '0;
      step("drain", 1'b0, 4'd0);
      gnt_ready = 1'b0;
      req = 8'h01;
      step("idle_ready_ignored", 1'b1, 4'd1);
      req = '0;
      step("withdrawn_held", 1'b1, 4'd1);
      gnt_ready = 1'b1;
      step("withdrawn_done", 1'b0, 4'd0);
      if (q.size() != 0) begin
         n_checks++;
         n_errors++;
         $error("FAIL scoreboard_leftover got=%0d exp=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/priority_arb_n.md
# priority_arb_n

Registered, parametrised priority arbiter with a valid/ready grant handshake. It is the sequential successor to the combinational priority encoder. It takes WIDTH request lines and issues one grant at a time, in fixed-priority mode (MSB wins) or round-robin mode. Each grant is reported as a 1-based index, 0 meaning none, using the same encoding as the encoder, plus a one-hot vector. It sits between a bank of requesters and a shared resource that consumes grants at its own rate.

## Interface
- WIDTH, default 8: number of request lines, 2..64.
- AW, default $clog2(WIDTH+1): grant index width. Derived; do not override.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  WIDTH  request vector; bit i is requester i.
- rr_mode  input  1  0 selects fixed priority, 1 selects round-robin. Sampled at each arbitration.
- lock  input  1  grant-lock request. Only active with the macro below; otherwise ignored.
- gnt_valid  output  1  a grant is presented.
- gnt_ready  input  1  consumer accepts the presented grant.
- gnt_idx  output  AW  1-based index of the granted requester; 0 when gnt_valid=0.
- gnt_onehot  output  WIDTH  one-hot grant; all-zero when gnt_valid=0.

## Operation
- States:
  - IDLE: gnt_valid=0.
  - GRANT: gnt_valid=1.
  - LOCKED: gnt_valid=1; exists only with the macro.
- Arbitration event: a rising edge where gnt_valid=0, or where gnt_valid=1 and gnt_ready=1.
- At an arbitration event:
  - req==0: go to IDLE; outputs cleared.
  - Otherwise: choose a winner, register it, and go to GRANT.
- Fixed mode: the winner is the highest set bit of req. gnt_idx = position+1, identical to the combinational encoder.
- Round-robin mode:
  - Pointer ptr (0..WIDTH-1).
  - The search starts at bit ptr and descends, wrapping from 0 to WIDTH-1. The first set bit wins.
  - On each accepted grant of index i (0-based), ptr <= (i==0) ? WIDTH-1 : i-1.
  - ptr updates only on acceptance, and only when rr_mode=1.
  - Fixed-mode grants leave ptr unchanged.
- Hold rule: while gnt_valid=1 and gnt_ready=0, gnt_idx and gnt_onehot are held stable. This applies even if req drops the granted bit or higher-priority bits rise.
- A withdrawn request that was already presented is still delivered. The consumer must tolerate this.
- Arithmetic: gnt_idx is zero-extended to AW bits. WIDTH=8 gives AW=4 with range 0..8.

## Timing
- Reset (asynchronous, immediate): gnt_valid=0, gnt_idx=0, gnt_onehot=0, ptr=WIDTH-1, state IDLE.
- Reset release: the first arbitration occurs at the first rising edge with rst_n=1.
- Latency: req sampled at edge N gives gnt_valid=1 after edge N (visible in cycle N+1). There is no combinational path from req to the outputs.
- Throughput: one grant per cycle while gnt_ready=1 and req≠0. On accept, the next winner is computed from the current req.
- gnt_ready while gnt_valid=0 is ignored.
- rst_n asserted mid-grant aborts it with no acceptance. ptr returns to WIDTH-1.
- Single requester in round-robin mode is re-granted every accept. No starvation of others: every set bit is granted within WIDTH accepts.

## Configuration
- Macro PRIORITY_ARB_N_LOCK_EN.
- Defined:
  - At an arbitration event in GRANT, if lock=1 and the current winner's req bit is still 1, the same grant is re-issued and the state moves to LOCKED. ptr is not advanced.
  - LOCKED exits at the next arbitration event where lock=0 or the winner's req bit is 0. Normal arbitration then resumes.
- Undefined: the lock port is present but ignored. The LOCKED state and its logic are not built.

## Test plan
- Reset and idle:
  - rst_n=0 for 3 cycles with req=8'hFF -> gnt_valid=0, gnt_idx=0, gnt_onehot=0.
  - Release with req=0 -> outputs stay 0.
- Fixed-priority sweep, rr_mode=0, gnt_ready=1:
  - req = 8'b00000001, 8'b00000011, … up to 8'hFF -> gnt_idx = 1..8 one cycle later.
  - req=0 -> gnt_idx=0, gnt_valid=0.
- Round-robin, rr_mode=1, gnt_ready=1, req=8'b10010010 held -> gnt_idx sequence 8, 5, 2, 8, 5, 2, matching gnt_onehot.
- Backpressure:
  - gnt_valid=1 with gnt_idx=5, then gnt_ready=0 for 4 cycles while req changes to 8'h80 -> gnt_idx stays 5.
  - gnt_ready=1 -> gnt_idx=8 next cycle.
- Async reset mid-grant: rst_n pulsed low between edges during gnt_valid=1 -> outputs 0 immediately. After release, rr order restarts from bit 7.
- Lock (PRIORITY_ARB_N_LOCK_EN), rr_mode=1, req=8'b00100100, lock=1:
  - gnt_idx=6 repeats over 3 accepts.
  - lock=0 -> next grant gnt_idx=3.
